// File: rtl/nios2_system_mem_loader_pkg.sv
// Shared types, default sizes and lane helpers for the on-chip RAM image loader.
// Optional read-back verify is enabled by defining MEM_LOADER_VERIFY_EN.
package nios2_system_mem_loader_pkg;

  localparam int unsigned DEPTH_DEF = 10240;
  localparam int unsigned AW_DEF    = 14;
  localparam int unsigned LW_DEF    = 16;
  localparam int unsigned DW        = 32;
  localparam int unsigned BEW       = 4;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    VRD,
    VCMP,
    DONE
  } state_e;

  // Byteenable for a word holding 'count' bytes in the low lanes.
  function automatic logic [BEW-1:0] lane_mask(input logic [2:0] count);
    logic [BEW-1:0] be;
    case (count)
      3'd1:    be = 4'b0001;
      3'd2:    be = 4'b0011;
      3'd3:    be = 4'b0111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Expand a byteenable into a per-bit mask.
  function automatic logic [DW-1:0] be_to_bits(input logic [BEW-1:0] be);
    logic [DW-1:0] bits;
    for (int i = 0; i < int'(BEW); i++) begin
      bits[8*i +: 8] = {8{be[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/nios2_system_byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word and flags word/image ends.
// Combinational outputs (_c) reflect the byte being accepted this cycle.
module nios2_system_byte_packer
  import nios2_system_mem_loader_pkg::*;
#(
  parameter int unsigned LW = LW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [LW-1:0] byte_len,
  input  logic          accept,
  input  logic [7:0]    byte_in,
  output logic [DW-1:0] word_c,
  output logic [2:0]    count_c,
  output logic          word_end_c,
  output logic          last_c
);

  logic [1:0]    lane_q, lane_d;
  logic [DW-1:0] pack_q, pack_d;
  logic [LW-1:0] remain_q, remain_d;

  // Lane insert, word-end and last-byte detection; pack register restarts per word.
  always_comb begin
    lane_d     = lane_q;
    pack_d     = pack_q;
    remain_d   = remain_q;
    word_c     = pack_q | (DW'(byte_in) << {lane_q, 3'b000});
    count_c    = 3'(lane_q) + 3'd1;
    last_c     = accept && (remain_q == LW'(1));
    word_end_c = accept && ((lane_q == 2'd3) || (remain_q == LW'(1)));
    if (load) begin
      lane_d   = 2'd0;
      pack_d   = '0;
      remain_d = byte_len;
    end else if (accept) begin
      remain_d = remain_q - LW'(1);
      if (word_end_c) begin
        lane_d = 2'd0;
        pack_d = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        pack_d = word_c;
      end
    end
  end

  // Packer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q   <= 2'd0;
      pack_q   <= '0;
      remain_q <= '0;
    end else begin
      lane_q   <= lane_d;
      pack_q   <= pack_d;
      remain_q <= remain_d;
    end
  end

endmodule

// File: rtl/nios2_system_mem_loader.sv
// Byte-stream to on-chip RAM loader: range check, FSM, address counter, checksum.
// Define MEM_LOADER_VERIFY_EN to read back and compare every written word.
module nios2_system_mem_loader
  import nios2_system_mem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned LW    = LW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [AW-1:0]  base_addr,
  input  logic [LW-1:0]  byte_len,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [AW-1:0]  mem_address,
  output logic [BEW-1:0] mem_byteenable,
  output logic           mem_chipselect,
  output logic           mem_write,
  output logic [DW-1:0]  mem_writedata,
  output logic           mem_clken,
  input  logic [DW-1:0]  mem_readdata,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [7:0]     checksum
);

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [7:0]     checksum_q, checksum_d;
  logic           error_q, error_d;
  logic [BEW-1:0] be_q, be_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic           last_q, last_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           cs_q, cs_d;
  logic           we_q, we_d;

  logic           load_c;
  logic           accept_c;
  logic           range_err_c;
  logic [LW:0]    words_c;
  logic [DW-1:0]  word_c;
  logic [2:0]     count_c;
  logic           word_end_c;
  logic           last_c;

  assign accept_c = in_valid & in_ready_q;

`ifndef MEM_LOADER_VERIFY_EN
  logic readdata_unused;
  assign readdata_unused = ^mem_readdata;
`endif

  // Image must end at or below DEPTH words; 32-bit sum cannot overflow.
  always_comb begin
    words_c     = ({1'b0, byte_len} + (LW+1)'(3)) >> 2;
    range_err_c = (32'(base_addr) + 32'(words_c)) > 32'(DEPTH);
  end

  nios2_system_byte_packer #(
    .LW (LW)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .load       (load_c),
    .byte_len   (byte_len),
    .accept     (accept_c),
    .byte_in    (in_data),
    .word_c     (word_c),
    .count_c    (count_c),
    .word_end_c (word_end_c),
    .last_c     (last_c)
  );

  // Next-state logic; registered outputs are decoded from the next state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    checksum_d = checksum_q;
    error_d    = error_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    last_d     = last_q;
    load_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_c     = 1'b1;
          error_d    = 1'b0;
          checksum_d = 8'd0;
          addr_d     = base_addr;
          if (byte_len == '0) begin
            state_d = DONE;
          end else if (range_err_c) begin
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (accept_c) begin
          checksum_d = checksum_q + in_data;
          if (word_end_c) begin
            state_d = WRITE;
            wdata_d = word_c;
            be_d    = lane_mask(count_c);
            last_d  = last_c;
          end
        end
      end
      WRITE: begin
`ifdef MEM_LOADER_VERIFY_EN
        state_d = VRD;
`else
        addr_d  = addr_q + AW'(1);
        state_d = last_q ? DONE : COLLECT;
`endif
      end
`ifdef MEM_LOADER_VERIFY_EN
      VRD: begin
        state_d = VCMP;
      end
      VCMP: begin
        if (|((mem_readdata ^ wdata_q) & be_to_bits(be_q))) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = last_q ? DONE : COLLECT;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d = (state_d == COLLECT);
    busy_d     = (state_d == COLLECT) || (state_d == WRITE) ||
                 (state_d == VRD) || (state_d == VCMP);
    done_d     = (state_d == DONE);
    cs_d       = (state_d == WRITE) || (state_d == VRD);
    we_d       = (state_d == WRITE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      checksum_q <= 8'd0;
      error_q    <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      last_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      checksum_q <= checksum_d;
      error_q    <= error_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_chipselect = cs_q;
  assign mem_write      = we_q;
  assign mem_writedata  = wdata_q;
  assign mem_clken      = 1'b1;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign checksum       = checksum_q;

endmodule
